// File: rtl/ccff_pkg.sv
// ccff_pkg: shared loader state encoding and default bitstream word width
package ccff_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  localparam int CCFF_WORD_W_DEFAULT = 32;
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: word PISO whose load cycle already presents bit 0, so the loader never waits a cycle
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int WORD_W = CCFF_WORD_W_DEFAULT,
  localparam int BL_W = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic              bit_out,
  output logic [BL_W-1:0]   bits_left
);
  logic [WORD_W-1:0] sreg;
  assign bit_out = load ? data[0] : sreg[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sreg      <= '0;
      bits_left <= '0;
    end else if (load) begin
      sreg      <= data >> 1;
      bits_left <= BL_W'(WORD_W - 1);
    end else if (shift) begin
      sreg      <= sreg >> 1;
      bits_left <= bits_left - 1'b1;
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes bitstream words onto ccff_head with a per-bit shift enable; CCFF_READBACK_EN adds tail readback
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = CCFF_WORD_W_DEFAULT,
  parameter int CHAIN_LEN = 4096,
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1),
  localparam int BL_W     = $clog2(WORD_W + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
`endif
);
  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [BL_W-1:0]  bits_left;
  logic             accept, last, more, emit, pbit;
  assign word_ready = state == FETCH;
  assign accept     = word_ready & word_valid;
  assign last       = bit_cnt == CNT_W'(CHAIN_LEN);
  assign more       = state == SHIFT && !last && bits_left != '0;
  assign emit       = accept | more;
  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk      (prog_clk),
    .rst_n    (prog_reset_n),
    .load     (accept),
    .shift    (more),
    .data     (word_data),
    .bit_out  (pbit),
    .bits_left(bits_left)
  );
  always_ff @(posedge prog_clk or negedge prog_reset_n)
    if (!prog_reset_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      ccff_head      <= 1'b0;
      chain_shift_en <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else if (abort) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      chain_shift_en <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state <= state == IDLE  ? (start ? FETCH : IDLE) :
               state == FETCH ? (accept ? SHIFT : FETCH) :
               state == SHIFT ? (last ? DONE : (bits_left == '0 ? FETCH : SHIFT)) : IDLE;
      busy           <= (state == IDLE && start) || state == FETCH || (state == SHIFT && !last);
      done           <= state == SHIFT && last;
      chain_shift_en <= emit;
      if (emit) begin
        ccff_head <= pbit;
        bit_cnt   <= bit_cnt + 1'b1;
      end else if (state == IDLE)
        bit_cnt <= '0;
    end
`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_acc, rb_next;
  logic [BL_W-1:0]   rb_idx;
  logic              rb_flush;
  assign rb_next  = rb_acc | (WORD_W'(ccff_tail) << rb_idx);
  // the last enabled cycle also flushes a partial word, zero-padded above
  assign rb_flush = chain_shift_en && (rb_idx == BL_W'(WORD_W - 1) || (state == SHIFT && last));
  always_ff @(posedge prog_clk or negedge prog_reset_n)
    if (!prog_reset_n) begin
      rb_acc   <= '0;
      rb_idx   <= '0;
      rb_valid <= 1'b0;
      rb_data  <= '0;
    end else if (abort) begin
      rb_acc   <= '0;
      rb_idx   <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= rb_flush;
      if (rb_flush) begin
        rb_data <= rb_next;
        rb_acc  <= '0;
        rb_idx  <= '0;
      end else if (chain_shift_en) begin
        rb_acc <= rb_next;
        rb_idx <= rb_idx + 1'b1;
      end
    end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif
endmodule
